// File: rtl/dot_update_writer.sv
// dot_update_writer
//   Processor-side writer for the VGA dot-position update interface.
//   The CPU pushes {id, x, y} entries into a FIFO. Each entry is replayed
//   as an X beat followed by a Y beat, and only while an update window
//   is open. The window is opened by the display's screenEnd level and
//   lasts WINDOW_CYCLES clocks, so dots never move mid-frame. Each beat is
//   held HOLD_CYCLES clocks so the slower pixel-clock domain can sample it.
//
//   Optional build macro: DOT_BOUNDS_CLAMP_EN
//     defined   : x > 639 is stored as 639 and y > 479 is stored as 479
//                 (the compare uses the full 32-bit unsigned input)
//     undefined : x and y are truncated to [9:0] and [8:0]
//
// Ports
//   clk        in   100 MHz system clock
//   reset      in   asynchronous, active-low reset
//   screenEnd  in   frame-boundary level (clk25 domain), synchronised here
//   cpu_wren   in   push request, one entry per cycle
//   cpu_dot_id in   dot index; ids >= NUM_DOTS are rejected
//   cpu_x      in   x location, bits [9:0] used
//   cpu_y      in   y location, bits [8:0] used
//   cpu_full   out  FIFO full (registered)
//   overflow   out  sticky: a push was dropped; cleared only by reset
//   busy       out  FIFO non-empty or a beat is in flight
//   frame_done out  one-cycle pulse when the update window closes
//   dotWren    out  beat valid
//   is_Yloc    out  0 = X beat, 1 = Y beat
//   dotID      out  dot index of the current beat
//   dotLoc     out  zero-extended location of the current beat

module dot_update_writer #(
    parameter int NUM_DOTS      = 38,
    parameter int FIFO_DEPTH    = 64,
    parameter int HOLD_CYCLES   = 4,
    parameter int WINDOW_CYCLES = 144000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic        cpu_wren,
    input  logic [31:0] cpu_dot_id,
    input  logic [31:0] cpu_x,
    input  logic [31:0] cpu_y,
    output logic        cpu_full,
    output logic        overflow,
    output logic        busy,
    output logic        frame_done,
    output logic        dotWren,
    output logic        is_Yloc,
    output logic [31:0] dotID,
    output logic [31:0] dotLoc
);

    localparam int ID_W   = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = ID_W + 19;
    localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYCLES);
    localparam logic [WIN_W:0]    MIN_LEFT  = (WIN_W + 1)'(2 * HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [AW:0]       DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef DOT_BOUNDS_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_X = 2'd1;
    localparam logic [1:0] SEND_Y = 2'd2;

    // Location formatting applied once, at push time.
    function automatic logic [9:0] fmt_x(input logic [31:0] v);
        if (CLAMP_EN && (v > 32'd639)) return 10'd639;
        return v[9:0];
    endfunction

    function automatic logic [8:0] fmt_y(input logic [31:0] v);
        if (CLAMP_EN && (v > 32'd479)) return 9'd479;
        return v[8:0];
    endfunction

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              empty, push_ok, pop;
    logic [ENT_W-1:0]  head;
    logic [ID_W-1:0]   head_id;
    logic [9:0]        head_x;
    logic [8:0]        head_y;

    logic              se_p0, se_p1, se_p2;
    logic              rise;
    logic [WIN_W-1:0]  win_cnt;
    logic              win_ok;

    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [8:0]        stage_y;

    // Full is a registered flag, so a push in the same cycle as a pop is
    // still refused when the FIFO was full before the edge.
    assign push_ok    = cpu_wren && !cpu_full && (cpu_dot_id < 32'(NUM_DOTS));
    assign empty      = (wr_ptr == rd_ptr);
    assign win_ok     = (win_cnt != '0) && ({1'b0, win_cnt} >= MIN_LEFT);
    assign pop        = (state == IDLE) && !empty && win_ok;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

    assign head    = mem[rd_ptr[AW-1:0]];
    assign head_id = head[ENT_W-1 -: ID_W];
    assign head_x  = head[18:9];
    assign head_y  = head[8:0];

    assign busy = !empty || (state != IDLE);

    // ---- push stage: FIFO storage (data only, not reset) ----
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= {cpu_dot_id[ID_W-1:0], fmt_x(cpu_x), fmt_y(cpu_y)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cpu_full <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            cpu_full <= ((wr_ptr_nxt - rd_ptr_nxt) == DEPTH_CNT);
            if (cpu_wren && !push_ok)
                overflow <= 1'b1;
        end
    end

    // ---- window stage: screenEnd synchroniser, edge detect, countdown ----
    assign rise = se_p1 && !se_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            se_p0      <= 1'b0;
            se_p1      <= 1'b0;
            se_p2      <= 1'b0;
            win_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            se_p0      <= screenEnd;
            se_p1      <= se_p0;
            se_p2      <= se_p1;
            frame_done <= !rise && (win_cnt == WIN_W'(1));
            if (rise)
                win_cnt <= WIN_LOAD;
            else if (win_cnt != '0)
                win_cnt <= win_cnt - WIN_W'(1);
        end
    end

    // ---- beat stage: X/Y replay with registered outputs ----
    always_ff @(posedge clk) begin
        if (pop)
            stage_y <= head_y;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            dotWren  <= 1'b0;
            is_Yloc  <= 1'b0;
            dotID    <= '0;
            dotLoc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= SEND_X;
                        hold_cnt <= HOLD_LAST;
                        dotWren  <= 1'b1;
                        is_Yloc  <= 1'b0;
                        dotID    <= 32'(head_id);
                        dotLoc   <= 32'(head_x);
                    end
                end
                SEND_X: begin
                    if (hold_cnt == '0) begin
                        state    <= SEND_Y;
                        hold_cnt <= HOLD_LAST;
                        is_Yloc  <= 1'b1;
                        dotLoc   <= 32'(stage_y);
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                SEND_Y: begin
                    // The window may already be closed here; a started
                    // entry always finishes its Y beat.
                    if (hold_cnt == '0) begin
                        state   <= IDLE;
                        dotWren <= 1'b0;
                        is_Yloc <= 1'b0;
                        dotID   <= '0;
                        dotLoc  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_update_writer.sv
// Testbench for dot_update_writer: randomized pushes are checked against a
// queue-based reference model and a per-window entry budget computed from
// the window length, hold time and entry period.

module tb_dot_update_writer;

    localparam int NUM_DOTS   = 38;
    localparam int FIFO_DEPTH = 64;
    localparam int HOLD       = 4;
    localparam int WIN        = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screenEnd = 1'b0;
    logic        cpu_wren = 1'b0;
    logic [31:0] cpu_dot_id = '0;
    logic [31:0] cpu_x = '0;
    logic [31:0] cpu_y = '0;
    logic        cpu_full, overflow, busy, frame_done, dotWren, is_Yloc;
    logic [31:0] dotID, dotLoc;

    typedef struct {
        logic [31:0] id;
        logic [31:0] x;
        logic [31:0] y;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   phase = 0;
    int   started = 0;

    always #5 clk = ~clk;

    dot_update_writer #(
        .NUM_DOTS(NUM_DOTS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .HOLD_CYCLES(HOLD),
        .WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .screenEnd(screenEnd),
        .cpu_wren(cpu_wren),
        .cpu_dot_id(cpu_dot_id),
        .cpu_x(cpu_x),
        .cpu_y(cpu_y),
        .cpu_full(cpu_full),
        .overflow(overflow),
        .busy(busy),
        .frame_done(frame_done),
        .dotWren(dotWren),
        .is_Yloc(is_Yloc),
        .dotID(dotID),
        .dotLoc(dotLoc)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_x(input logic [31:0] v);
`ifdef DOT_BOUNDS_CLAMP_EN
        if (v > 639) return 639;
`endif
        return v % 1024;
    endfunction

    function automatic logic [31:0] ref_y(input logic [31:0] v);
`ifdef DOT_BOUNDS_CLAMP_EN
        if (v > 479) return 479;
`endif
        return v % 512;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Drives one push for the coming edge; full_before is cpu_full as seen
    // just before this push is presented.
    task automatic push(input logic [31:0] id, input logic [31:0] x, input logic [31:0] y,
                        output logic full_before);
        ent_t e;
        @(posedge clk); #1;
        full_before = cpu_full;
        cpu_wren = 1'b1;
        cpu_dot_id = id;
        cpu_x = x;
        cpu_y = y;
        if (id < NUM_DOTS && q.size() < FIFO_DEPTH) begin
            e.id = id;
            e.x  = ref_x(x);
            e.y  = ref_y(y);
            q.push_back(e);
        end
    endtask

    task automatic push_end();
        @(posedge clk); #1;
        cpu_wren = 1'b0;
    endtask

    // Raises screenEnd for 4 clocks and watches long enough for the window
    // to close and the last started entry to finish.
    task automatic frame(output int t_wren, output int t_done, output int n_done);
        t_wren = -1;
        t_done = -1;
        n_done = 0;
        @(posedge clk); #1;
        screenEnd = 1'b1;
        for (int c = 1; c <= WIN + 2 * HOLD + 12; c++) begin
            @(posedge clk); #1;
            if (c == 4) screenEnd = 1'b0;
            if (dotWren && t_wren < 0) t_wren = c;
            if (frame_done) begin
                n_done++;
                if (t_done < 0) t_done = c;
            end
        end
    endtask

    task automatic check_beat(input int p);
        bit y_beat;
        y_beat = (p >= HOLD);
        check_eq("beat_wren", dotWren, 1);
        check_eq("beat_is_y", is_Yloc, y_beat);
        check_eq("beat_id", dotID, cur.id);
        check_eq(y_beat ? "beat_loc_y" : "beat_loc_x", dotLoc, y_beat ? cur.y : cur.x);
    endtask

    // Beat monitor: each entry must appear as HOLD X cycles, HOLD Y cycles,
    // then at least one idle cycle, in push order.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                phase = 0;
            end else if (phase == 0) begin
                if (dotWren) begin
                    if (q.size() == 0) begin
                        check_eq("extra_beat", dotWren, 0);
                    end else begin
                        cur = q.pop_front();
                        started++;
                        check_beat(0);
                        phase = 1;
                    end
                end
            end else begin
                if (phase < 2 * HOLD) check_beat(phase);
                else check_eq("beat_gap", dotWren, 0);
                phase = (phase == 2 * HOLD) ? 0 : phase + 1;
            end
        end
    end

    initial begin
        int   tw, td, nd, s0, seen, c, per_win, guard;
        logic fb;

        // Entries that may start in one window: a start needs >= 2*HOLD
        // window cycles left and starts are 2*HOLD+1 apart.
        per_win = (WIN - 2 * HOLD) / (2 * HOLD + 1) + 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dotWren", dotWren, 0);
        check_eq("rst_is_Yloc", is_Yloc, 0);
        check_eq("rst_dotLoc", dotLoc, 0);
        check_eq("rst_cpu_full", cpu_full, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        reset = 1'b1;
        mon_en = 1'b1;

        // Single entry, latency and window length
        push(5, 100, 200, fb);
        push_end();
        check_eq("busy_queued", busy, 1);
        s0 = started;
        frame(tw, td, nd);
        check_eq("first_wren_latency", tw, 4);
        check_eq("frame_done_time", td, 3 + WIN);
        check_eq("frame_done_width", nd, 1);
        check_eq("single_started", started - s0, 1);
        check_eq("single_busy_after", busy, 0);

        // Queued entries wait for the window
        for (int i = 0; i < 3; i++) begin
            push($urandom_range(0, NUM_DOTS - 1), $urandom, $urandom, fb);
        end
        push_end();
        seen = 0;
        repeat (10000) begin
            @(posedge clk); #1;
            if (dotWren) seen = 1;
        end
        check_eq("no_beat_outside_window", seen, 0);
        check_eq("busy_while_waiting", busy, 1);
        s0 = started;
        frame(tw, td, nd);
        check_eq("hold_win1_count", started - s0, min2(3, per_win));
        s0 = started;
        frame(tw, td, nd);
        check_eq("hold_win2_count", started - s0, 3 - min2(3, per_win));
        check_eq("hold_model_empty", q.size(), 0);

        // Bad id is rejected
        push(38, 1, 2, fb);
        push_end();
        check_eq("badid_overflow", overflow, 1);
        check_eq("badid_busy", busy, 0);
        check_eq("badid_full", cpu_full, 0);
        s0 = started;
        frame(tw, td, nd);
        check_eq("badid_no_beats", started - s0, 0);

        // Reset in the middle of an X beat
        push(7, 300, 400, fb);
        push_end();
        q.delete();
        mon_en = 1'b0;
        @(posedge clk); #1;
        screenEnd = 1'b1;
        c = 0;
        while (!dotWren && c < 12) begin
            @(posedge clk); #1;
            c++;
            if (c == 4) screenEnd = 1'b0;
        end
        screenEnd = 1'b0;
        check_eq("wren_before_reset", dotWren, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("reset_drops_wren", dotWren, 0);
        check_eq("reset_clears_loc", dotLoc, 0);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset_busy", busy, 0);
        check_eq("post_reset_overflow", overflow, 0);
        mon_en = 1'b1;
        s0 = started;
        frame(tw, td, nd);
        check_eq("post_reset_no_beats", started - s0, 0);
        check_eq("post_reset_frame_done", td, 3 + WIN);

        // Fill to full and overflow by one
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            push($urandom_range(0, NUM_DOTS - 1), $urandom, $urandom, fb);
            if (i == FIFO_DEPTH - 1) check_eq("full_before_last", fb, 0);
            if (i == FIFO_DEPTH) check_eq("full_after_depth", fb, 1);
        end
        push_end();
        check_eq("full_overflow", overflow, 1);
        check_eq("full_flag", cpu_full, 1);
        check_eq("full_model_size", q.size(), FIFO_DEPTH);
        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            int exp_n;
            exp_n = min2(q.size(), per_win);
            s0 = started;
            frame(tw, td, nd);
            check_eq("drain_per_window", started - s0, exp_n);
            if (guard == 0) check_eq("full_clears", cpu_full, 0);
            guard++;
        end
        check_eq("drain_model_empty", q.size(), 0);
        check_eq("drain_busy", busy, 0);

        // Random mix with out-of-range ids and the clamp boundary values
        for (int i = 0; i < 12; i++) begin
            push($urandom_range(0, NUM_DOTS + 7), $urandom, $urandom, fb);
        end
        push(3, 700, 500, fb);
        push(4, 639, 479, fb);
        push_end();
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            int exp_n;
            exp_n = min2(q.size(), per_win);
            s0 = started;
            frame(tw, td, nd);
            check_eq("mix_per_window", started - s0, exp_n);
            guard++;
        end
        check_eq("mix_model_empty", q.size(), 0);
        check_eq("mix_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dot_update_writer.md
Name: dot_update_writer

Overview:
- Processor-side writer for the VGA dot-position update interface (dotWren / is_Yloc / dotID / dotLoc).
- Buffers CPU dot-position writes in a FIFO and replays each one as an X beat followed by a Y beat.
- Replay happens only inside a blanking window opened by the display's screenEnd, so dots never move mid-frame.
- Holds each beat long enough to be sampled by the display's clk/4 pixel-clock domain.

Parameters:
NUM_DOTS, 38, number of dots; IDs >= NUM_DOTS are rejected at push
FIFO_DEPTH, 64, entries (power of 2); one entry = {id, x, y}
HOLD_CYCLES, 4, clk cycles each output beat is held (>= clk/clk25 ratio)
WINDOW_CYCLES, 144000, clk cycles the update window stays open after screenEnd rises (45 lines * 800 px * 4)

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-low reset
screenEnd  input  1  frame-boundary level from the VGA timing generator (clk25 domain, high for 4 clk cycles)
cpu_wren  input  1  push request, one entry per clk cycle high
cpu_dot_id  input  32  dot index
cpu_x  input  32  x location; bits [9:0] used
cpu_y  input  32  y location; bits [8:0] used
cpu_full  output  1  FIFO full
overflow  output  1  sticky: push dropped (full or bad id); cleared only by reset
busy  output  1  FIFO non-empty or a beat is in flight
frame_done  output  1  one-clk pulse when the window closes
dotWren  output  1  beat valid
is_Yloc  output  1  0 = X beat, 1 = Y beat
dotID  output  32  dot index of current beat
dotLoc  output  32  zero-extended location of current beat

Behaviour:
- Reset (reset low, async): all outputs 0, FIFO empty, state IDLE, window counter 0. Asserting reset mid-beat drops dotWren immediately. Queued entries are discarded.
- Push:
  - cpu_wren=1 and FIFO not full and cpu_dot_id < NUM_DOTS: store {id, x[9:0], y[8:0]}.
  - Otherwise the entry is dropped and overflow is set.
  - cpu_full is registered and reflects occupancy after each edge.
  - Simultaneous push and pop in one cycle is legal. When full, push-with-pop still rejects the push, since full is evaluated before the pop.
- Window:
  - screenEnd is registered twice, and its rising edge is detected.
  - On the rise, win_cnt loads WINDOW_CYCLES and decrements each clk down to 0.
  - The window is open while win_cnt != 0.
  - A rise seen while the window is already open reloads win_cnt.
  - frame_done pulses for one cycle on the cycle win_cnt goes 1 -> 0.
- FSM:
  - IDLE: if window open, FIFO non-empty, and win_cnt >= 2*HOLD_CYCLES, then pop the head into a staging register and go to SEND_X.
  - SEND_X: dotWren=1, is_Yloc=0, dotID=id, dotLoc={22'b0, x}, held for HOLD_CYCLES. Then go to SEND_Y.
  - SEND_Y: dotWren=1, is_Yloc=1, dotLoc={23'b0, y}, held for HOLD_CYCLES. Then return to IDLE, with dotWren=0 for at least 1 cycle.
  - Outputs are registered and stable for the whole beat, with no glitch between the X and Y beats other than is_Yloc/dotLoc changing on the boundary.
  - An entry that has started always completes both beats even if the window closes. A new entry never starts with fewer than 2*HOLD_CYCLES window cycles left.
- Latency: first dotWren occurs 4 clk cycles after screenEnd rises at clk (2 sync + edge + pop).
- Throughput: one entry per 2*HOLD_CYCLES+1 cycles.
- busy = FIFO non-empty OR state != IDLE.

Optional Feature:
DOT_BOUNDS_CLAMP_EN
- Defined: at push, x values > 639 are stored as 639 and y values > 479 are stored as 479; the comparison uses full 32-bit unsigned input.
- Undefined: plain truncation to [9:0] / [8:0].

Test Plan:
- Reset mid-SEND_X (reset low at beat cycle 2): dotWren=0 same cycle; after release, busy=0 and no beats until a new push plus screenEnd.
- Push (id=5, x=100, y=200), then pulse screenEnd for 4 clk: dotWren high 4 clk with is_Yloc=0, dotID=5, dotLoc=100; then 4 clk with is_Yloc=1, dotLoc=200; frame_done after 144000 clk.
- Push 3 entries with screenEnd low for 10000 clk: dotWren stays 0, busy=1; after screenEnd, exactly 6 beats in push order.
- Push 65 entries back-to-back: cpu_full=1 after the 64th; the 65th is dropped, overflow=1, and 64 entries drain.
- Push id=38: overflow=1, FIFO unchanged, busy=0.
- WINDOW_CYCLES=20, HOLD_CYCLES=4, 5 entries queued: exactly 2 entries sent per window, with the remainder in following windows. With DOT_BOUNDS_CLAMP_EN, push x=700, y=500: dotLoc beats are 639 and 479.
